// File: rtl/fsm_pkg.sv
// Shared definitions for the serial-to-parallel deserializer.
//   state_t       : word-assembly FSM states (IDLE, SHIFT)
//   DEFAULT_WIDTH : default number of bits per word
//   bit_index()   : maps the k-th received bit to its position in the word
package fsm_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Position in the assembled word of the k-th received bit (k = 0 is the sync bit).
  function automatic int bit_index(input int k, input int width, input bit msb_first);
    int idx;
    if (msb_first) begin
      idx = width - 1 - k;
    end else begin
      idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// One-deep output holding register with a valid/ready handshake.
//   clk, reset   : clock and asynchronous active-low reset
//   load, din    : a completed word is offered for one cycle
//   ready        : consumer accepts dout when dout_valid is also high
//   dout         : held word (keeps its old value after being consumed)
//   dout_valid   : dout holds an unconsumed word
//   overrun      : one-cycle pulse when an offered word is dropped because
//                  the register is still full and not being consumed
module word_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic             overrun_r;
  logic             accept_s;

  // Held word is leaving on this edge.
  assign accept_s = valid_r & ready;

  // Load/accept arbitration: a consumed slot may be refilled on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r    <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (load && (!valid_r || accept_s)) begin
        data_r    <= din;
        valid_r   <= 1'b1;
        overrun_r <= 1'b0;
      end else if (load) begin
        // Full and not draining: keep the held word, drop the new one.
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= 1'b0;
        if (accept_s) begin
          valid_r <= 1'b0;
        end
      end
    end
  end

  assign dout       = data_r;
  assign dout_valid = valid_r;
  assign overrun    = overrun_r;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer with sync-marker framing.
//   clk, reset   : clock and asynchronous active-low reset
//   sin          : serial data bit, sampled when sin_valid is high
//   sin_valid    : qualifies sin and sync
//   sync         : marks the first bit of a word
//   dout         : assembled word (held until consumed)
//   dout_valid   : dout holds an unconsumed word
//   dout_ready   : consumer accepts dout on an edge with dout_valid high
//   busy         : a word is partially assembled
//   overrun      : one-cycle pulse, completed word dropped (holding reg full)
//   framing_err  : one-cycle pulse, sync arrived mid-word, partial word dropped
module sipo_deserializer
  import fsm_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             framing_err
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  IDX0 = CW'(bit_index(0, WIDTH, MSB_FIRST));
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_nxt_s;
  logic [CW-1:0]    idx_s;
  logic             load_s;
  logic             framing_nxt_s;
  logic             framing_err_r;
  logic             busy_r;

  // Bit counter doubles as the received-bit number; map it to a word position.
  assign idx_s = CW'(bit_index(int'(cnt_r), WIDTH, MSB_FIRST));

  // Next-state, shift-register and counter logic of the framing FSM.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    shreg_nxt_s   = shreg_r;
    load_s        = 1'b0;
    framing_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sin_valid && sync) begin
          shreg_nxt_s       = {WIDTH{1'b0}};
          shreg_nxt_s[IDX0] = sin;
          cnt_nxt_s         = ONE;
          state_nxt_s       = SHIFT;
        end else begin
          // Unframed bits are ignored until a sync marker arrives.
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (!sin_valid) begin
          state_nxt_s = SHIFT;
        end else if (sync) begin
          // Resync: restart assembly with this bit as the new bit 0.
          framing_nxt_s     = 1'b1;
          shreg_nxt_s       = {WIDTH{1'b0}};
          shreg_nxt_s[IDX0] = sin;
          cnt_nxt_s         = ONE;
        end else begin
          shreg_nxt_s[idx_s] = sin;
          if (cnt_r == LAST) begin
            load_s      = 1'b1;
            cnt_nxt_s   = {CW{1'b0}};
            state_nxt_s = IDLE;
          end else begin
            cnt_nxt_s = cnt_r + ONE;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CW{1'b0}};
        shreg_nxt_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // FSM state, assembly registers and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      cnt_r         <= {CW{1'b0}};
      shreg_r       <= {WIDTH{1'b0}};
      framing_err_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      shreg_r       <= shreg_nxt_s;
      framing_err_r <= framing_nxt_s;
      busy_r        <= (state_nxt_s == SHIFT);
    end
  end

  // The completing word is the next shift-register value (last bit inserted).
  word_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .din       (shreg_nxt_s),
    .ready     (dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .overrun   (overrun)
  );

  assign busy        = busy_r;
  assign framing_err = framing_err_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       sin;
  logic       sin_valid;
  logic       sync;
  logic       dout_ready;

  logic [3:0] dout1, dout0;
  logic       dout_valid1, dout_valid0;
  logic       busy1, busy0;
  logic       overrun1, overrun0;
  logic       framing_err1, framing_err0;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected words for the MSB-first (1) and LSB-first (0) instances.
  logic [3:0] exp_q1[$];
  logic [3:0] exp_q0[$];

  // Event counters maintained by the monitor (MSB-first instance).
  int busy_cnt  = 0;
  int vld_cnt   = 0;
  int ovr_cnt   = 0;
  int fe_cnt    = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .dout(dout1), .dout_valid(dout_valid1), .dout_ready(dout_ready),
    .busy(busy1), .overrun(overrun1), .framing_err(framing_err1)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .dout(dout0), .dout_valid(dout_valid0), .dout_ready(dout_ready),
    .busy(busy0), .overrun(overrun0), .framing_err(framing_err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] e_msb, input logic [3:0] e_lsb);
    exp_q1.push_back(e_msb);
    exp_q0.push_back(e_lsb);
  endtask

  task automatic send_bit(input logic b, input logic s);
    @(posedge clk); #1;
    sin = b; sin_valid = 1'b1; sync = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sin_valid = 1'b0; sync = 1'b0; sin = 1'b0;
    end
  endtask

  // Sends w[3] first (with sync), then w[2], w[1], w[0].
  task automatic send_word(input logic [3:0] w);
    logic [3:0] v;
    v = w;
    send_bit(v[3], 1'b1);
    send_bit(v[2], 1'b0);
    send_bit(v[1], 1'b0);
    send_bit(v[0], 1'b0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      busy_cnt += int'(busy1);
      vld_cnt  += int'(dout_valid1);
      ovr_cnt  += int'(overrun1);
      fe_cnt   += int'(framing_err1);
      if (dout_valid1 && dout_ready) begin
        if (exp_q1.size() == 0) begin
          chk("unexpected_word_msb", 32'(dout1), 32'hffff_ffff);
        end else begin
          chk("word_msb", 32'(dout1), 32'(exp_q1.pop_front()));
        end
      end
      if (dout_valid0 && dout_ready) begin
        if (exp_q0.size() == 0) begin
          chk("unexpected_word_lsb", 32'(dout0), 32'hffff_ffff);
        end else begin
          chk("word_lsb", 32'(dout0), 32'(exp_q0.pop_front()));
        end
      end
    end
  endtask

  task automatic stimulus();
    int b_busy, b_vld, b_ovr, b_fe;
    reset = 1'b0; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout1), 32'h0);
    chk("rst_valid", 32'(dout_valid1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    chk("rst_overrun", 32'(overrun1), 32'h0);
    chk("rst_framing", 32'(framing_err1), 32'h0);
    reset = 1'b1;

    // Basic word 1,0,1,1.
    b_busy = busy_cnt; b_vld = vld_cnt;
    push(4'b1011, 4'b1101);
    send_word(4'b1011);
    idle(3);
    chk("basic_busy_cycles", 32'(busy_cnt - b_busy), 32'd3);
    chk("basic_valid_cycles", 32'(vld_cnt - b_vld), 32'd1);

    // Gapped: 3 idle cycles between bits 2 and 3.
    b_busy = busy_cnt; b_ovr = ovr_cnt; b_fe = fe_cnt;
    push(4'b1011, 4'b1101);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    idle(3);
    send_bit(1'b1, 1'b0);
    idle(3);
    chk("gap_busy_cycles", 32'(busy_cnt - b_busy), 32'd6);
    chk("gap_errors", 32'((ovr_cnt - b_ovr) + (fe_cnt - b_fe)), 32'd0);

    // Backpressure: second word dropped with one overrun pulse.
    b_ovr = ovr_cnt;
    dout_ready = 1'b0;
    push(4'b1011, 4'b1101);
    send_word(4'b1011);
    send_word(4'b0110);
    idle(2);
    chk("bp_overrun_pulses", 32'(ovr_cnt - b_ovr), 32'd1);
    chk("bp_dout_msb", 32'(dout1), 32'hb);
    chk("bp_dout_lsb", 32'(dout0), 32'hd);
    chk("bp_valid_held", 32'(dout_valid1), 32'h1);
    dout_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_falls", 32'(dout_valid1), 32'h0);
    chk("bp_dout_retained", 32'(dout1), 32'hb);
    idle(1);

    // Accept and completion on the same edge.
    b_ovr = ovr_cnt;
    dout_ready = 1'b0;
    push(4'b1011, 4'b1101);
    send_word(4'b1011);
    push(4'b0110, 4'b0110);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    dout_ready = 1'b1;
    idle(1);
    chk("sim_dout", 32'(dout1), 32'h6);
    chk("sim_valid", 32'(dout_valid1), 32'h1);
    idle(2);
    chk("sim_no_overrun", 32'(ovr_cnt - b_ovr), 32'd0);

    // Sync on bit 3 restarts the word: new word 0,0,1,1.
    b_fe = fe_cnt; b_ovr = ovr_cnt;
    push(4'b0011, 4'b1100);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    idle(3);
    chk("fe_pulses", 32'(fe_cnt - b_fe), 32'd1);
    chk("fe_no_overrun", 32'(ovr_cnt - b_ovr), 32'd0);

    // Reset mid-word with a word held: everything clears before the next edge.
    dout_ready = 1'b0;
    send_word(4'b1001);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    @(posedge clk); #1;
    sin_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy1), 32'h0);
    chk("mid_rst_valid", 32'(dout_valid1), 32'h0);
    chk("mid_rst_dout_msb", 32'(dout1), 32'h0);
    chk("mid_rst_dout_lsb", 32'(dout0), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    dout_ready = 1'b1;
    b_busy = busy_cnt; b_vld = vld_cnt;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    idle(3);
    chk("nosync_busy", 32'(busy_cnt - b_busy), 32'd0);
    chk("nosync_valid", 32'(vld_cnt - b_vld), 32'd0);

    chk("queue_msb_empty", 32'(exp_q1.size()), 32'd0);
    chk("queue_lsb_empty", 32'(exp_q0.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL timeout: got no completion expected stimulus to finish");
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
